// File: rtl/huc_io_pkg.sv
// Shared constants, register decode and read-FSM state type for the HuC6280
// interrupt-controller / interval-timer bus responder.
package huc_io_pkg;

    localparam int          PRESCALE_DEFAULT   = 1024;
    localparam logic [15:0] TIMER_BASE_DEFAULT = 16'h0C00;
    localparam logic [15:0] IRQC_BASE_DEFAULT  = 16'h1402;

    localparam logic [15:0] OFS_COUNT  = 16'd0;
    localparam logic [15:0] OFS_CTRL   = 16'd1;
    localparam logic [15:0] OFS_MASK   = 16'd0;
    localparam logic [15:0] OFS_STATUS = 16'd1;

    // Bit positions shared by the status and mask registers
    localparam int TIQ  = 2;
    localparam int IRQ1 = 1;
    localparam int IRQ2 = 0;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } rd_state_t;

    typedef enum logic [2:0] {
        REG_NONE,
        REG_COUNT,
        REG_CTRL,
        REG_MASK,
        REG_STATUS
    } reg_id_t;

    function automatic reg_id_t decode_reg(
        input logic [15:0] ab,
        input logic [15:0] timer_base,
        input logic [15:0] irqc_base
    );
        decode_reg = REG_NONE;
        if (ab == timer_base + OFS_COUNT) begin
            decode_reg = REG_COUNT;
        end else if (ab == timer_base + OFS_CTRL) begin
            decode_reg = REG_CTRL;
        end else if (ab == irqc_base + OFS_MASK) begin
            decode_reg = REG_MASK;
        end else if (ab == irqc_base + OFS_STATUS) begin
            decode_reg = REG_STATUS;
        end
    endfunction

endpackage

// File: rtl/huc_timer.sv
// Interval timer: prescaler, 7-bit down counter with reload, and the
// timer-pending flag that is set on underflow and cleared by an ack.
module huc_timer
    import huc_io_pkg::*;
#(
    parameter int PRESCALE = PRESCALE_DEFAULT
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic       load,
    input  logic       ack,
    input  logic       reload_we,
    input  logic [6:0] reload_in,
    output logic       tick,
    output logic [6:0] count,
    output logic       tpend
);

    localparam int            PW         = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);

    logic [PW-1:0] prescaler_reg;
    logic [PW-1:0] prescaler_next;
    logic [6:0]    count_reg;
    logic [6:0]    count_next;
    logic [6:0]    reload_reg;
    logic          tpend_reg;
    logic          tpend_next;
    logic          underflow;

    always_comb begin
        tick           = enable && (prescaler_reg == PRESC_LAST);
        underflow      = tick && !load && (count_reg == 7'd0);
        prescaler_next = prescaler_reg;
        count_next     = count_reg;

        // A start (load) always beats a coincident tick.
        if (load) begin
            prescaler_next = '0;
            count_next     = reload_reg;
        end else if (enable) begin
            if (tick) begin
                prescaler_next = '0;
                count_next     = (count_reg == 7'd0) ? reload_reg : count_reg - 7'd1;
            end else begin
                prescaler_next = prescaler_reg + PW'(1);
            end
        end

        // Underflow wins over a same-cycle ack.
        tpend_next = underflow ? 1'b1 : (ack ? 1'b0 : tpend_reg);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            prescaler_reg <= '0;
            count_reg     <= '0;
            reload_reg    <= '0;
            tpend_reg     <= 1'b0;
        end else begin
            prescaler_reg <= prescaler_next;
            count_reg     <= count_next;
            tpend_reg     <= tpend_next;
            if (reload_we) begin
                reload_reg <= reload_in;
            end
        end
    end

    assign count = count_reg;
    assign tpend = tpend_reg;

endmodule

// File: rtl/irq_timer_resp.sv
// Bus responder for the interrupt controller and interval timer: register
// decode, one-wait-state read path, and the registered CPU IRQ line.
module irq_timer_resp
    import huc_io_pkg::*;
#(
    parameter int          PRESCALE   = PRESCALE_DEFAULT,
    parameter logic [15:0] TIMER_BASE = TIMER_BASE_DEFAULT,
    parameter logic [15:0] IRQC_BASE  = IRQC_BASE_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] AB,
    input  logic [7:0]  DO,
    input  logic        WE,
    input  logic        ext_irq1,
    input  logic        ext_irq2,
    output logic [7:0]  DI,
    output logic        RDY,
    output logic        IRQ,
    output logic        sel
);

    reg_id_t   reg_id;
    rd_state_t state_reg;
    rd_state_t state_next;

    logic       rd_hit;
    logic       wr_hit;
    logic       load;
    logic       ack;
    logic       reload_we;
    logic       enable_reg;
    logic [2:0] mask_reg;
    logic [7:0] di_reg;
    logic [7:0] di_next;
    logic [7:0] rd_data;
    logic       irq_reg;
    logic       irq_next;
    logic       rdy;
    logic [2:0] src;
    logic [2:0] src_active;
    logic [6:0] count;
    logic       tpend;
    logic       unused_tick;
    logic       unused_do_msb;

    assign reg_id = decode_reg(AB, TIMER_BASE, IRQC_BASE);
    assign sel    = (reg_id != REG_NONE);
    assign rd_hit = sel && !WE;
    assign wr_hit = sel && WE;

    assign reload_we = wr_hit && (reg_id == REG_COUNT);
    assign ack       = wr_hit && (reg_id == REG_STATUS);
    // Only a rising edge of enable restarts the count.
    assign load      = wr_hit && (reg_id == REG_CTRL) && DO[0] && !enable_reg;

    assign unused_do_msb = DO[7];

    huc_timer #(
        .PRESCALE (PRESCALE)
    ) u_timer (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable_reg),
        .load      (load),
        .ack       (ack),
        .reload_we (reload_we),
        .reload_in (DO[6:0]),
        .tick      (unused_tick),
        .count     (count),
        .tpend     (tpend)
    );

    assign src[TIQ]  = tpend;
    assign src[IRQ1] = ext_irq1;
    assign src[IRQ2] = ext_irq2;

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_src
            assign src_active[gi] = src[gi] & ~mask_reg[gi];
        end
    endgenerate

    assign irq_next = |src_active;

    always_comb begin
        rd_data = 8'h00;
        case (reg_id)
            REG_COUNT:  rd_data = {1'b0, count};
            REG_CTRL:   rd_data = {7'b0, enable_reg};
            REG_MASK:   rd_data = {5'b0, mask_reg};
            REG_STATUS: rd_data = {5'b0, src};
            default:    rd_data = 8'h00;
        endcase
    end

    always_comb begin
        state_next = state_reg;
        di_next    = di_reg;
        rdy        = 1'b1;
        case (state_reg)
            IDLE: begin
                if (rd_hit) begin
                    state_next = WAIT;
                    di_next    = rd_data;
                    // A reset cycle never stalls the CPU.
                    rdy        = !reset;
                end
            end
            WAIT: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg  <= IDLE;
            di_reg     <= 8'h00;
            enable_reg <= 1'b0;
            mask_reg   <= 3'b000;
            irq_reg    <= 1'b0;
        end else begin
            state_reg <= state_next;
            di_reg    <= di_next;
            irq_reg   <= irq_next;
            if (wr_hit && (reg_id == REG_CTRL)) begin
                enable_reg <= DO[0];
            end
            if (wr_hit && (reg_id == REG_MASK)) begin
                mask_reg <= DO[2:0];
            end
        end
    end

    assign DI  = di_reg;
    assign RDY = rdy;
    assign IRQ = irq_reg;

endmodule

// File: tb/tb_irq_timer_resp.sv
// Self-checking bench for irq_timer_resp: directed scenarios plus random bus
// traffic compared against a cycle-level behavioural model.
`timescale 1ns/1ps
module tb_irq_timer_resp;

    localparam int          PRESCALE  = 1024;
    localparam logic [15:0] IDLE_ADDR = 16'h2000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] AB;
    logic [7:0]  DO;
    logic        WE;
    logic        ext_irq1;
    logic        ext_irq2;
    logic [7:0]  DI;
    logic        RDY;
    logic        IRQ;
    logic        sel;

    int n_compared   = 0;
    int n_mismatched = 0;
    int cycle_no     = 0;
    logic last_rdy;

    // behavioural model state
    int       m_reload, m_count, m_presc;
    bit       m_enable, m_tpend, m_irq, m_wait;
    bit [2:0] m_mask;
    bit [7:0] m_di;

    irq_timer_resp dut (
        .clk      (clk),
        .reset    (rst_n),
        .AB       (AB),
        .DO       (DO),
        .WE       (WE),
        .ext_irq1 (ext_irq1),
        .ext_irq2 (ext_irq2),
        .DI       (DI),
        .RDY      (RDY),
        .IRQ      (IRQ),
        .sel      (sel)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_compared++;
        if (got !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cycle_no);
        end
    endtask

    function automatic int reg_idx(input logic [15:0] a);
        case (a)
            16'h0C00: return 0;
            16'h0C01: return 1;
            16'h1402: return 2;
            16'h1403: return 3;
            default:  return -1;
        endcase
    endfunction

    function automatic bit [7:0] model_read(input int r);
        case (r)
            0:       return 8'(m_count);
            1:       return {7'b0, m_enable};
            2:       return {5'b0, m_mask};
            3:       return {5'b0, m_tpend, ext_irq1, ext_irq2};
            default: return 8'h00;
        endcase
    endfunction

    task automatic model_reset();
        m_reload = 0; m_count = 0; m_presc = 0;
        m_enable = 0; m_tpend = 0; m_irq = 0; m_wait = 0;
        m_mask = 0; m_di = 0;
    endtask

    // One rising edge of the specified behaviour; every decision uses pre-edge values.
    task automatic model_step(input int r, input bit we, input bit [7:0] d);
        bit underflow;
        bit new_irq;
        if (rst_n !== 1'b1) begin
            model_reset();
            return;
        end
        new_irq = (m_tpend && !m_mask[2]) || (ext_irq1 && !m_mask[1]) || (ext_irq2 && !m_mask[0]);
        if (!m_wait && r >= 0 && !we) begin
            m_di   = model_read(r);
            m_wait = 1;
        end else begin
            m_wait = 0;
        end
        underflow = 0;
        if (we && r == 1 && d[0] && !m_enable) begin
            m_count = m_reload;
            m_presc = 0;
        end else if (m_enable) begin
            if (m_presc == PRESCALE - 1) begin
                if (m_count == 0) begin
                    underflow = 1;
                    m_count   = m_reload;
                end else begin
                    m_count = m_count - 1;
                end
            end
            m_presc = (m_presc + 1) % PRESCALE;
        end
        if (underflow)               m_tpend = 1;
        else if (we && r == 3)       m_tpend = 0;
        if (we && r == 0)            m_reload = d & 8'h7F;
        if (we && r == 1)            m_enable = d[0];
        if (we && r == 2)            m_mask   = d[2:0];
        m_irq = new_irq;
    endtask

    // Drive one bus cycle from a falling edge; check combinational outputs
    // before the edge and registered outputs just after it.
    task automatic drive_cycle(input logic [15:0] a, input logic we, input logic [7:0] d);
        int r;
        r  = reg_idx(a);
        AB = a; WE = we; DO = d;
        #1;
        check_val("sel", sel, (r >= 0));
        check_val("rdy", RDY, !((rst_n === 1'b1) && !m_wait && r >= 0 && !we));
        last_rdy = RDY;
        @(posedge clk);
        model_step(r, we, d);
        cycle_no++;
        #1;
        check_val("irq", IRQ, m_irq);
        check_val("di", DI, m_di);
        @(negedge clk);
    endtask

    task automatic bus_write(input logic [15:0] a, input logic [7:0] d);
        drive_cycle(a, 1'b1, d);
    endtask

    task automatic bus_read(input logic [15:0] a, output logic [7:0] data);
        int low;
        low = 0;
        drive_cycle(a, 1'b0, 8'h00);
        if (last_rdy == 1'b0) low++;
        data = DI;
        drive_cycle(a, 1'b0, 8'h00);
        if (last_rdy == 1'b0) low++;
        check_val("rd_wait_states", low, 1);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive_cycle(IDLE_ADDR, 1'b0, 8'h00);
    endtask

    task automatic wait_irq_rise(input int limit, output int edge_no);
        int n;
        n = 0;
        edge_no = -1;
        while (IRQ !== 1'b1 && n < limit) begin
            idle(1);
            n++;
        end
        if (IRQ === 1'b1) edge_no = cycle_no;
        else check_val("irq_timeout", IRQ, 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cycle_no);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] rd;
        int e0, r1, r2, u3;
        bit saw_irq;
        logic [15:0] addrs [8];
        addrs = '{16'h0C00, 16'h0C01, 16'h1402, 16'h1403, 16'h0C02, 16'h1401, 16'h1404, IDLE_ADDR};

        rst_n = 1'b0; AB = IDLE_ADDR; WE = 1'b0; DO = 8'h00;
        ext_irq1 = 1'b0; ext_irq2 = 1'b0;
        model_reset();
        @(negedge clk);

        // reset state
        idle(2);
        check_val("rst_rdy", RDY, 1);
        check_val("rst_irq", IRQ, 0);
        check_val("rst_di", DI, 8'h00);
        rst_n = 1'b1;
        bus_read(16'h1403, rd);
        check_val("t1_status", rd, 8'h00);

        // timer period and first underflow
        bus_write(16'h0C00, 8'h03);
        bus_write(16'h0C01, 8'h01);
        e0 = cycle_no;
        wait_irq_rise(6000, r1);
        check_val("t2_irq_delay", r1 - e0, 4097);
        bus_read(16'h1403, rd);
        check_val("t2_status", rd, 8'h04);

        // ack and periodic reload
        bus_write(16'h1403, 8'h5A);
        check_val("t3_irq_hold", IRQ, 1);
        idle(1);
        check_val("t3_irq_low", IRQ, 0);
        wait_irq_rise(6000, r2);
        check_val("t3_period", r2 - r1, 4096);
        bus_write(16'h1403, 8'h00);
        idle(1);

        // mask written on the underflow edge
        u3 = (r2 - 1) + 4096;
        while (cycle_no < u3 - 1) idle(1);
        bus_write(16'h1402, 8'h04);
        idle(1);
        check_val("t4_masked", IRQ, 0);
        bus_read(16'h1403, rd);
        check_val("t4_status", rd, 8'h04);
        check_val("t4_masked2", IRQ, 0);
        bus_write(16'h1402, 8'h00);
        check_val("t4_unmask_lat", IRQ, 0);
        idle(1);
        check_val("t4_unmask", IRQ, 1);

        // external source
        bus_write(16'h1403, 8'h00);
        idle(2);
        check_val("t5_pre", IRQ, 0);
        ext_irq1 = 1'b1;
        idle(1);
        check_val("t5_ext_irq", IRQ, 1);
        bus_read(16'h1403, rd);
        check_val("t5_status", rd, 8'h02);
        ext_irq1 = 1'b0;
        idle(2);

        // reset during WAIT with count at 2
        while (cycle_no < u3 + 1100) idle(1);
        drive_cycle(16'h0C00, 1'b0, 8'h00);
        check_val("t6_count", DI, 8'h02);
        rst_n = 1'b0;
        drive_cycle(16'h0C00, 1'b0, 8'h00);
        rst_n = 1'b1;
        AB = IDLE_ADDR; WE = 1'b0;
        #1;
        check_val("t6_rdy", RDY, 1);
        bus_read(16'h0C01, rd);
        check_val("t6_enable", rd, 8'h00);
        bus_read(16'h0C00, rd);
        check_val("t6_count_rst", rd, 8'h00);
        saw_irq = 0;
        for (int i = 0; i < 5000; i++) begin
            idle(1);
            if (IRQ !== 1'b0) saw_irq = 1;
        end
        check_val("t6_no_irq", saw_irq, 0);

        // random traffic against the model
        for (int i = 0; i < 15000; i++) begin
            logic [15:0] a;
            logic        we;
            logic [7:0]  d;
            rst_n = ($urandom_range(0, 599) != 0);
            if ($urandom_range(0, 49) == 0) ext_irq1 = 1'($urandom);
            if ($urandom_range(0, 49) == 0) ext_irq2 = 1'($urandom);
            a  = addrs[$urandom_range(0, 7)];
            we = ($urandom_range(0, 2) == 0);
            d  = 8'($urandom);
            if (a == 16'h0C00) d = d & 8'h83;
            if (a == 16'h0C01 && we) begin
                if ($urandom_range(0, 7) != 0) we = 1'b0;
                d[0] = ($urandom_range(0, 7) != 0);
            end
            drive_cycle(a, we, d);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule

// File: doc/irq_timer_resp.md
# irq_timer_resp

Memory-mapped bus responder for the HuC6280 interrupt controller and interval timer. It sits on the `cpu_65c02` bus beside `memory` and decodes its register window from `AB`/`WE`/`DO`. It returns read data on `DI` with one inserted wait state via `RDY`, and drives the CPU `IRQ` line from the masked pending sources.

## Interface
- `PRESCALE`, 1024: clk cycles per timer decrement.
- `TIMER_BASE`, 16'h0C00: timer register pair base (`+0` count/reload, `+1` control).
- `IRQC_BASE`, 16'h1402: IRQ controller base (`+0` mask, `+1` status/ack).

Ports:
- `clk`  in  1  single system clock; all state changes on rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `AB`  in  16  CPU address bus.
- `DO`  in  8  CPU write data.
- `WE`  in  1  CPU write strobe, high = write.
- `ext_irq1`, `ext_irq2`  in  1 each  level-sensitive external interrupt sources.
- `DI`  out  8  read data to CPU; meaningful only when this block is selected.
- `RDY`  out  1  low inserts a wait state.
- `IRQ`  out  1  active-high, level interrupt to CPU.
- `sel`  out  1  address hits one of the four registers; the top level uses it to mux `DI` against `memory`.

## Operation
- Registers: `reload[6:0]`, `count[6:0]`, `enable`, `prescaler[9:0]`, `mask[2:0]` (1 = disabled), `tpend`.
- `TIMER_BASE+0`:
  - Write sets `reload` to `DO[6:0]`.
  - Read returns `{1'b0, count}`.
  - A write does not disturb `count`; the new value takes effect at the next reload.
- `TIMER_BASE+1`:
  - Write sets `enable` to `DO[0]`.
  - A 0→1 transition loads `count <= reload` and `prescaler <= 0`.
  - Read returns `{7'b0, enable}`.
- `IRQC_BASE+0`: write sets `mask` to `DO[2:0]`; read returns `{5'b0, mask}`.
- `IRQC_BASE+1`:
  - Read returns `{5'b0, tpend, ext_irq1, ext_irq2}`.
  - Any write clears `tpend` (the ack).
- Timer, while `enable`:
  - `prescaler` increments. On reaching `PRESCALE-1` it wraps to 0 and issues a tick.
  - On a tick with `count==0`: `count <= reload` and `tpend <= 1`.
  - On a tick with any other `count`: `count` decrements.
  - Period is (`reload`+1)×`PRESCALE` cycles.
  - With `enable` low, `count` and `prescaler` freeze.
- `IRQ = (tpend & ~mask[2]) | (ext_irq1 & ~mask[1]) | (ext_irq2 & ~mask[0])`, registered (one-cycle delay from source).
- Read FSM states:
  - IDLE: a read hit (`sel & ~WE`) latches the register value into `DI`, moves to WAIT, and holds `RDY=0` (combinational) that cycle.
  - WAIT: `RDY=1` with `DI` valid; next state is IDLE.
- Writes: zero wait states. They are captured on the edge where `sel & WE`, and `RDY` stays 1.
- Simultaneous events:
  - Underflow and ack in the same cycle: set wins, `tpend` stays 1.
  - Enable 0→1 write and a tick in the same cycle: the load wins.
  - Write to `reload` on the underflow cycle: the old `reload` value is used.

## Timing
- Reset values: `DI`=0, `RDY`=1, `IRQ`=0, `sel` combinational.
- Internal reset values: `reload`=`count`=0, `enable`=0, `prescaler`=0, `mask`=0, `tpend`=0, FSM in IDLE.
- Reset asserted mid-access (including in WAIT) returns to IDLE with `RDY`=1 on the next edge.
- Read latency: the data edge ends the wait cycle, so the CPU samples `DI` 2 cycles after `AB` is presented.
- A repeated read at the same address after WAIT inserts a fresh wait state.
- `tpend` rises on the edge of the underflow tick; `IRQ` rises one edge later.
- The ack write clears `tpend` on its edge; `IRQ` falls one edge later.
- Mask changes reach `IRQ` after one edge.

## Structure
- Package `huc_io_pkg` holds:
  - Register offsets and base-address constants.
  - `PRESCALE` default.
  - Read-FSM state enum {IDLE, WAIT}.
  - Bit positions in the status/mask registers (TIQ=2, IRQ1=1, IRQ2=0).
- One sub-module, `huc_timer`, contains prescaler, count, reload and `tpend` set logic. It has ports for enable, load, ack and tick. Bus decode, the read FSM and the IRQ combine stay in the top.

## Test plan
- Reset with `reset`=0 for 2 cycles → `RDY`=1, `IRQ`=0, read of `0x1403` returns 8'h00 after exactly one `RDY`-low cycle.
- Write `0x0C00`=8'h03, then `0x0C01`=8'h01 → `IRQ` rises 4×1024+1 cycles after the enable edge. A read of `0x1403` returns 8'h04.
- With `tpend` set, write any value to `0x1403` → `IRQ` low one cycle later. The next pulse comes 4096 cycles after the previous underflow.
- Write `0x1402`=8'h04 during underflow → `tpend` sets (status 8'h04) but `IRQ` stays 0. Writing `0x1402`=8'h00 then raises `IRQ` one cycle later.
- Drive `ext_irq1`=1 with mask 0 → `IRQ`=1 next cycle. Read of `0x1403` returns 8'h02.
- Assert `reset` in the WAIT cycle of a read and while the timer counts at `count`=2 → next edge: `RDY`=1, `enable`=0. The count then reads 8'h00 and no `IRQ` occurs afterwards.
